// File: rtl/sn_prot_if.sv
// Protocol register bus between the UART protocol master and its register-file responder.
// 7-bit address, 8-bit data, single enable strobe qualifying a read or write.
interface sn_prot_if;
    logic       prot_enable;
    logic       prot_r0w1;
    logic [6:0] prot_addr;
    logic [7:0] prot_wdata;
    logic [7:0] prot_rdata;

    modport master (
        output prot_enable,
        output prot_r0w1,
        output prot_addr,
        output prot_wdata,
        input  prot_rdata
    );

    modport slave (
        input  prot_enable,
        input  prot_r0w1,
        input  prot_addr,
        input  prot_wdata,
        output prot_rdata
    );
endinterface

// File: rtl/sn_prot_regfile.sv
// Protocol register file: staging registers, input commit, timestep sequencer, spike counters.
// Optional build macro SN_PROT_STEP_TIMEOUT_EN adds a per-step watchdog on net_step_done.
module sn_prot_regfile #(
    parameter int P_NUM_INPUTS   = 23,
    parameter int P_NUM_OUTPUTS  = 3,
    parameter int P_TS_WIDTH     = 16,
    parameter int P_STEP_TIMEOUT = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    sn_prot_if.slave                          prot,
    output logic                              net_in_we_o,
    output logic [$clog2(P_NUM_INPUTS+1)-1:0] net_in_addr_o,
    output logic [23:0]                       net_in_data_o,
    output logic                              net_step_o,
    input  logic                              net_step_done_i,
    input  logic [P_NUM_OUTPUTS-1:0]          net_out_spike_i,
    output logic                              busy_o
);
    localparam int AW = $clog2(P_NUM_INPUTS + 1);
    localparam logic [P_TS_WIDTH-1:0] TS_ZERO = {P_TS_WIDTH{1'b0}};
    localparam logic [P_TS_WIDTH-1:0] TS_ONE  = {{(P_TS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e                  state_q;
    logic [P_TS_WIDTH-1:0]   ts_max_q;
    logic [P_TS_WIDTH-1:0]   ts_cur_q;
    logic [15:0]             in_addr_q;
    logic [23:0]             in_data_q;
    logic [7:0]              out_sel_q;
    logic [7:0]              cnt_q [P_NUM_OUTPUTS];
    logic                    done_q;
    logic                    timeout_q;
    logic                    net_step_q;
    logic                    net_in_we_q;
    logic [AW-1:0]           net_in_addr_q;
    logic [23:0]             net_in_data_q;
    logic [7:0]              rdata_s;
    logic [7:0]              cnt_sel_s;
    logic [P_TS_WIDTH-1:0]   ts_next_s;

`ifdef SN_PROT_STEP_TIMEOUT_EN
    localparam int TW = $clog2(P_STEP_TIMEOUT + 1);
    logic [TW-1:0]           tmo_q;
`endif

    wire wr_s     = prot.prot_enable & prot.prot_r0w1;
    wire start_s  = wr_s && (prot.prot_addr == 7'd0) && (prot.prot_wdata == 8'h01);
    wire abort_s  = wr_s && (prot.prot_addr == 7'd0) && (prot.prot_wdata == 8'h00);
    wire commit_s = wr_s && (prot.prot_addr == 7'd5) && prot.prot_wdata[0];
    wire addr_ok_s = (in_addr_q != 16'd0) && (in_addr_q <= 16'(P_NUM_INPUTS));

    assign ts_next_s     = ts_cur_q + TS_ONE;
    assign busy_o        = (state_q != S_IDLE);
    assign net_step_o    = net_step_q;
    assign net_in_we_o   = net_in_we_q;
    assign net_in_addr_o = net_in_addr_q;
    assign net_in_data_o = net_in_data_q;

    // Staging registers written directly from the bus; accepted even while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_max_q  <= TS_ZERO;
            in_addr_q <= 16'd0;
            in_data_q <= 24'd0;
            out_sel_q <= 8'd0;
        end else if (wr_s) begin
            case (prot.prot_addr)
                7'd3:    ts_max_q[P_TS_WIDTH-1:8] <= prot.prot_wdata[P_TS_WIDTH-9:0];
                7'd4:    ts_max_q[7:0]            <= prot.prot_wdata;
                7'd6:    in_addr_q[15:8]          <= prot.prot_wdata;
                7'd7:    in_addr_q[7:0]           <= prot.prot_wdata;
                7'd9:    in_data_q[23:16]         <= prot.prot_wdata;
                7'd10:   in_data_q[15:8]          <= prot.prot_wdata;
                7'd11:   in_data_q[7:0]           <= prot.prot_wdata;
                7'd12:   out_sel_q                <= prot.prot_wdata;
                default: ;
            endcase
        end
    end

    // Commit strobe: one cycle, only from idle with an in-range 1-based input address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            net_in_we_q   <= 1'b0;
            net_in_addr_q <= {AW{1'b0}};
            net_in_data_q <= 24'd0;
        end else begin
            net_in_we_q <= 1'b0;
            if (commit_s && (state_q == S_IDLE) && addr_ok_s) begin
                net_in_we_q   <= 1'b1;
                net_in_addr_q <= in_addr_q[AW-1:0];
                net_in_data_q <= in_data_q;
            end
        end
    end

    // Timestep sequencer with spike counters and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            net_step_q <= 1'b0;
            ts_cur_q   <= TS_ZERO;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < P_NUM_OUTPUTS; i++) cnt_q[i] <= 8'd0;
`ifdef SN_PROT_STEP_TIMEOUT_EN
            tmo_q      <= {TW{1'b0}};
`endif
        end else begin
            net_step_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        ts_cur_q  <= TS_ZERO;
                        timeout_q <= 1'b0;
                        for (int i = 0; i < P_NUM_OUTPUTS; i++) cnt_q[i] <= 8'd0;
                        if (ts_max_q == TS_ZERO) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q     <= 1'b0;
                            state_q    <= S_STEP;
                            net_step_q <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (abort_s) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
`ifdef SN_PROT_STEP_TIMEOUT_EN
                        tmo_q   <= {TW{1'b0}};
`endif
                    end
                end
                S_WAIT: begin
                    // abort wins over a coincident done so the late step is not counted
                    if (abort_s) begin
                        state_q <= S_IDLE;
                    end else if (net_step_done_i) begin
                        for (int i = 0; i < P_NUM_OUTPUTS; i++) begin
                            if (net_out_spike_i[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
                        end
                        ts_cur_q <= ts_next_s;
                        if (ts_next_s == ts_max_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_STEP;
                            net_step_q <= 1'b1;
                        end
`ifdef SN_PROT_STEP_TIMEOUT_EN
                    end else if (tmo_q == TW'(P_STEP_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + {{(TW-1){1'b0}}, 1'b1};
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Zero-latency read mux; out-of-range OUT_SEL reads as zero
    always_comb begin
        cnt_sel_s = 8'h00;
        for (int i = 0; i < P_NUM_OUTPUTS; i++) begin
            cnt_sel_s = (out_sel_q == 8'(i)) ? cnt_q[i] : cnt_sel_s;
        end
        case (prot.prot_addr)
            7'd0:    rdata_s = {7'd0, busy_o};
            7'd1:    rdata_s = {6'd0, timeout_q, done_q};
            7'd3:    rdata_s = 8'(ts_max_q >> 8);
            7'd4:    rdata_s = ts_max_q[7:0];
            7'd6:    rdata_s = in_addr_q[15:8];
            7'd7:    rdata_s = in_addr_q[7:0];
            7'd9:    rdata_s = in_data_q[23:16];
            7'd10:   rdata_s = in_data_q[15:8];
            7'd11:   rdata_s = in_data_q[7:0];
            7'd12:   rdata_s = out_sel_q;
            7'd13:   rdata_s = cnt_sel_s;
            7'd14:   rdata_s = 8'(ts_cur_q >> 8);
            7'd15:   rdata_s = ts_cur_q[7:0];
            default: rdata_s = 8'h00;
        endcase
    end

    assign prot.prot_rdata = rdata_s;
endmodule

// File: tb/tb_sn_prot_regfile.sv
// Self-checking bench for sn_prot_regfile: scoreboarded register reads and commit strobes,
// stepped runs with spike patterns, saturation, abort, reset and step-timeout behaviour.
module tb_sn_prot_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        net_in_we;
    logic [4:0]  net_in_addr;
    logic [23:0] net_in_data;
    logic        net_step;
    logic        net_step_done;
    logic [2:0]  net_out_spike;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;
    int steps_seen = 0;
    int obs_n = 0;
    int cm_rd = 0;
    int exp_cm = 0;
    int base = 0;
    logic [28:0] obs_v [32];
    logic [7:0]  rd_q [$];
    logic [28:0] cm_q [$];
    logic [2:0]  pat_tab [3];

    always #5 clk = ~clk;

    sn_prot_if pif ();

`ifdef SN_PROT_STEP_TIMEOUT_EN
    sn_prot_regfile #(.P_STEP_TIMEOUT(10)) dut (
`else
    sn_prot_regfile dut (
`endif
        .clk             (clk),
        .rst             (rst),
        .prot            (pif),
        .net_in_we_o     (net_in_we),
        .net_in_addr_o   (net_in_addr),
        .net_in_data_o   (net_in_data),
        .net_step_o      (net_step),
        .net_step_done_i (net_step_done),
        .net_out_spike_i (net_out_spike),
        .busy_o          (busy)
    );

    // Record every cycle the commit strobe is high
    always @(negedge clk) begin
        if (net_in_we) begin
            if (obs_n < 32) obs_v[obs_n] = {net_in_addr, net_in_data};
            obs_n++;
        end
    end

    // Count net_step pulses
    always @(posedge clk) begin
        if (net_step) steps_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        pif.prot_enable = 1'b1;
        pif.prot_r0w1   = 1'b1;
        pif.prot_addr   = a;
        pif.prot_wdata  = d;
        @(negedge clk);
        pif.prot_enable = 1'b0;
        pif.prot_r0w1   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [7:0] e);
        rd_q.push_back(e);
        pif.prot_addr = a;
        #1;
        check_eq(tag, 32'(pif.prot_rdata), 32'(rd_q.pop_front()));
    endtask

    task automatic commit_drain();
        repeat (3) @(negedge clk);
        while (cm_q.size() > 0 && cm_rd < obs_n && cm_rd < 32) begin
            check_eq("commit_val", 32'(obs_v[cm_rd]), 32'(cm_q.pop_front()));
            cm_rd++;
        end
        check_eq("commit_cnt", 32'(obs_n), 32'(exp_cm));
    endtask

    task automatic wait_steps(input int k);
        int t = 0;
        while (steps_seen < k && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (steps_seen < k) check_eq("step_wait", 32'(steps_seen), 32'(k));
    endtask

    task automatic step_done(input int k, input logic [2:0] sp);
        wait_steps(k);
        net_step_done = 1'b1;
        net_out_spike = sp;
        @(negedge clk);
        net_step_done = 1'b0;
        net_out_spike = 3'b000;
    endtask

    task automatic run(input int n, input bit fixed);
        for (int k = 1; k <= n; k++) begin
            step_done(base + k, fixed ? 3'b001 : pat_tab[(k-1) % 3]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pif.prot_enable = 1'b0;
        pif.prot_r0w1   = 1'b0;
        pif.prot_addr   = 7'd0;
        pif.prot_wdata  = 8'd0;
        net_step_done   = 1'b0;
        net_out_spike   = 3'b000;
        pat_tab[0] = 3'b101;
        pat_tab[1] = 3'b001;
        pat_tab[2] = 3'b111;

        repeat (3) @(negedge clk);
        check_eq("rst_we", 32'(net_in_we), 32'd0);
        check_eq("rst_step", 32'(net_step), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rd("rst_ctrl", 7'd0, 8'h00);
        rd("rst_status", 7'd1, 8'h00);
        rst = 1'b0;

        // Input commit: valid, zero address, out of range, MSB set, top boundary
        wr(7'd6, 8'h00); wr(7'd7, 8'h05);
        wr(7'd9, 8'h12); wr(7'd10, 8'h34); wr(7'd11, 8'h56);
        rd("in_data1", 7'd10, 8'h34);
        rd("in_addr_lsb", 7'd7, 8'h05);
        cm_q.push_back({5'd5, 24'h123456}); exp_cm++;
        wr(7'd5, 8'h01);
        commit_drain();
        rd("in_commit_rd", 7'd5, 8'h00);
        wr(7'd7, 8'h00); wr(7'd5, 8'h01);
        wr(7'd7, 8'd24); wr(7'd5, 8'h01);
        wr(7'd6, 8'h01); wr(7'd7, 8'h05); wr(7'd5, 8'h01);
        commit_drain();
        wr(7'd6, 8'h00); wr(7'd7, 8'd23); wr(7'd11, 8'hAB);
        cm_q.push_back({5'd23, 24'h1234AB}); exp_cm++;
        wr(7'd5, 8'h01);
        commit_drain();

        // Three-step run with spike patterns 101, 001, 111
        wr(7'd3, 8'h00); wr(7'd4, 8'h03);
        base = steps_seen;
        wr(7'd0, 8'h01);
        rd("run3_ctrl_busy", 7'd0, 8'h01);
        run(3, 1'b0);
        wait_idle("run3_idle");
        repeat (4) @(negedge clk);
        check_eq("run3_steps", 32'(steps_seen - base), 32'd3);
        wr(7'd12, 8'd0); rd("run3_cnt0", 7'd13, 8'd3);
        wr(7'd12, 8'd1); rd("run3_cnt1", 7'd13, 8'd1);
        wr(7'd12, 8'd2); rd("run3_cnt2", 7'd13, 8'd2);
        wr(7'd12, 8'd3); rd("run3_cnt_oob", 7'd13, 8'd0);
        rd("run3_tscur_msb", 7'd14, 8'd0);
        rd("run3_tscur_lsb", 7'd15, 8'd3);
        rd("run3_ctrl", 7'd0, 8'h00);
        rd("run3_status", 7'd1, 8'h01);

        // 300 steps, output 0 spiking every step: counter saturates
        wr(7'd3, 8'h01); wr(7'd4, 8'h2C);
        base = steps_seen;
        wr(7'd0, 8'h01);
        run(300, 1'b1);
        wait_idle("sat_idle");
        check_eq("sat_steps", 32'(steps_seen - base), 32'd300);
        wr(7'd12, 8'd0); rd("sat_cnt0", 7'd13, 8'd255);
        wr(7'd12, 8'd1); rd("sat_cnt1", 7'd13, 8'd0);
        rd("sat_tscur_msb", 7'd14, 8'h01);
        rd("sat_tscur_lsb", 7'd15, 8'h2C);
        rd("sat_status", 7'd1, 8'h01);

        // TS_MAX = 0: done immediately, no step, counters cleared
        wr(7'd3, 8'h00); wr(7'd4, 8'h00);
        base = steps_seen;
        wr(7'd0, 8'h01);
        check_eq("ts0_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("ts0_steps", 32'(steps_seen - base), 32'd0);
        rd("ts0_status", 7'd1, 8'h01);
        wr(7'd12, 8'd0); rd("ts0_cnt0", 7'd13, 8'd0);

        // Abort after two of five steps, with a coincident done that must be dropped
        wr(7'd4, 8'h05);
        base = steps_seen;
        wr(7'd0, 8'h01);
        step_done(base + 1, 3'b001);
        step_done(base + 2, 3'b001);
        wr(7'd0, 8'h01);
        rd("abort_restart_ign", 7'd15, 8'd2);
        rd("abort_busy_rd", 7'd0, 8'h01);
        wr(7'd5, 8'h01);
        wait_steps(base + 3);
        pif.prot_enable = 1'b1; pif.prot_r0w1 = 1'b1;
        pif.prot_addr = 7'd0; pif.prot_wdata = 8'h00;
        net_step_done = 1'b1; net_out_spike = 3'b001;
        @(negedge clk);
        pif.prot_enable = 1'b0; pif.prot_r0w1 = 1'b0;
        net_step_done = 1'b0; net_out_spike = 3'b000;
        rd("abort_ctrl", 7'd0, 8'h00);
        rd("abort_status", 7'd1, 8'h00);
        rd("abort_tscur", 7'd15, 8'd2);
        rd("abort_cnt0", 7'd13, 8'd2);
        repeat (3) @(negedge clk);
        check_eq("abort_steps", 32'(steps_seen - base), 32'd3);
        commit_drain();

        // No net_step_done at all: watchdog expiry or indefinite wait
        base = steps_seen;
        wr(7'd0, 8'h01);
        wait_steps(base + 1);
`ifdef SN_PROT_STEP_TIMEOUT_EN
        repeat (9) @(negedge clk);
        check_eq("tmo_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("tmo_busy_after", 32'(busy), 32'd0);
        rd("tmo_status", 7'd1, 8'h02);
`else
        repeat (1000) @(negedge clk);
        check_eq("notmo_busy", 32'(busy), 32'd1);
        rd("notmo_status", 7'd1, 8'h00);
        wr(7'd0, 8'h00);
        check_eq("notmo_abort", 32'(busy), 32'd0);
`endif

        // Asynchronous reset in the middle of a run
        base = steps_seen;
        wr(7'd0, 8'h01);
        wait_steps(base + 1);
        check_eq("mrst_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_step", 32'(net_step), 32'd0);
        check_eq("mrst_we", 32'(net_in_we), 32'd0);
        rd("mrst_ctrl", 7'd0, 8'h00);
        rd("mrst_status", 7'd1, 8'h00);
        rd("mrst_cnt", 7'd13, 8'h00);
        rd("mrst_tsmax", 7'd4, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/sn_prot_regfile.md
Name: sn_prot_regfile

Overview:
Responder end of the 7-bit-address/8-bit-data protocol register bus driven by the UART protocol master. Decodes register reads and writes and holds the staging registers for timestep limit, input address and input current. Commits input writes to the network and sequences execution one timestep at a time. Accumulates per-output spike counts and returns them through a select/readout register pair.

Parameters:
P_NUM_INPUTS, 23, number of network inputs; valid input addresses are 1..P_NUM_INPUTS
P_NUM_OUTPUTS, 3, number of output neurons with spike counters
P_TS_WIDTH, 16, width of timestep max/current registers (fixed MSB/LSB byte split)
P_STEP_TIMEOUT, 1000, cycles allowed for net_step_done (only with SN_PROT_STEP_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
prot_enable  in  1  qualifies all prot_* inputs
prot_r0w1  in  1  0=read, 1=write
prot_addr  in  7  register address
prot_wdata  in  8  write data
prot_rdata  out  8  read data; combinational from prot_addr, zero latency
net_in_we  out  1  one-cycle input-current write strobe
net_in_addr  out  $clog2(P_NUM_INPUTS+1)  input index (1-based)
net_in_data  out  24  input current {DATA2,DATA1,DATA0}
net_step  out  1  one-cycle pulse: execute one timestep
net_step_done  in  1  network finished current step
net_out_spike  in  P_NUM_OUTPUTS  output spikes; sampled when net_step_done=1
busy  out  1  run in progress (same as CTRL bit0)

Behaviour:
- Register map (R/W unless noted; unmapped reads 0, unmapped writes ignored):
  0 CTRL: read {7'b0,running}; write 0x01 starts if idle; write 0x00 aborts if running
  1 STATUS (RO): bit0 done (set on normal completion, cleared on start); bit1 timeout; others 0
  3/4 TS_MAX MSB/LSB; 5 IN_COMMIT (write bit0=1 issues commit; reads 0)
  6/7 IN_ADDR MSB/LSB; 9/10/11 IN_DATA bytes 2/1/0; 12 OUT_SEL
  13 OUT_CNT (RO): counter[OUT_SEL]; 0 if OUT_SEL >= P_NUM_OUTPUTS
  14/15 TS_CUR MSB/LSB (RO)
- Writes take effect on the clk edge where prot_enable&prot_r0w1. Reads have no side effects.
- Reset: all registers, counters, flags, prot_rdata source, net_in_we, net_step, busy = 0; FSM IDLE.
- Commit: on an IN_COMMIT write with bit0=1, net_in_we=1 for exactly the next cycle, with net_in_addr/net_in_data taken from the staging registers. The commit is dropped (no strobe) if running, IN_ADDR==0, or IN_ADDR>P_NUM_INPUTS.
- Sequencer FSM: IDLE, STEP, WAIT.
  - IDLE: on start write, clear TS_CUR, all counters, done and timeout. If TS_MAX==0, set done and stay IDLE (busy never asserts). Otherwise go to STEP.
  - STEP: net_step=1 for one cycle, then go to WAIT.
  - WAIT: on net_step_done, each counter with net_out_spike[i]=1 increments, saturating at 255, and TS_CUR increments. If TS_CUR+1==TS_MAX, set done and go to IDLE; otherwise go to STEP.
- net_step_done outside WAIT is ignored.
- Abort (CTRL write 0x00 in STEP/WAIT): go to IDLE on that edge. Counters and TS_CUR are held, done stays 0. A net_step_done arriving on the same edge is not counted.
- Start write while running is ignored. A staging-register write while running is accepted but takes no effect until the next commit.
- busy = (state != IDLE). CTRL read bit0 drops to 0 in the cycle after the final net_step_done.

Optional Feature:
SN_PROT_STEP_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If it reaches P_STEP_TIMEOUT without net_step_done, go to IDLE, set STATUS bit1, and leave done=0. Counter clears on every WAIT entry.
- Undefined: WAIT waits indefinitely and STATUS bit1 reads 0.

Test Plan:
- Reset mid-run (busy=1) -> all outputs 0 immediately, CTRL/STATUS/OUT_CNT read 0.
- Write IN_ADDR=0x0005, IN_DATA=0x12_34_56, IN_COMMIT=0x01 -> single net_in_we pulse with addr=5, data=0x123456. Repeat with IN_ADDR=0 and IN_ADDR=24 -> no pulse.
- TS_MAX=3, start, drive spikes 3'b101,3'b001,3'b111 on each done -> exactly 3 net_step pulses; OUT_SEL=0/1/2 reads 3/1/2; TS_CUR=3; CTRL=0; STATUS=0x01.
- TS_MAX=300, out[0] spikes every step -> OUT_CNT[0] saturates at 255. TS_MAX=0 start -> no net_step, STATUS done=1.
- Abort after 2 of 5 steps -> IDLE, TS_CUR=2, done=0. Done pulse coincident with abort is not counted. Start while running is ignored.
- With SN_PROT_STEP_TIMEOUT_EN, P_STEP_TIMEOUT=10, no net_step_done -> IDLE after 10 WAIT cycles, STATUS=0x02. Without the macro, still busy after 1000 cycles.
